// File: rtl/mpc_pkg.sv
// Shared state encoding and default timing for the FCS-MPC gate driver.
package mpc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DT   = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_e;

    localparam int CTRL_DIV_DEF = 100;
    localparam int DEAD_T_DEF   = 4;
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/mpc_ctrl_timer.sv
// Control-period counter; raises tick in the last cycle of each period while enabled.
module mpc_ctrl_timer
    import mpc_pkg::*;
#(
    parameter int CTRL_DIV = CTRL_DIV_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CTRL_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by en so that dropping en on the last count never issues a strobe.
    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/mpc_gate_driver.sv
// Half-bridge gate driver for the FCS-MPC decision: samples u once per period and
// commutates through a dead-time state so gate_hi and gate_lo never overlap.
module mpc_gate_driver
    import mpc_pkg::*;
#(
    parameter int CTRL_DIV = CTRL_DIV_DEF,
    parameter int DEAD_T   = DEAD_T_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,
    input  logic             en,
    input  logic             u,
    output logic             gate_hi,
    output logic             gate_lo,
    output logic             sample_stb,
    output logic [CNT_W-1:0] sw_cnt,
    output logic [1:0]       io_oeb
);

    localparam int DW = (DEAD_T > 1) ? $clog2(DEAD_T) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_T - 1);

    logic             tick;
    state_e           state_q, state_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic             u_q, u_d;
    logic [CNT_W-1:0] sw_q, sw_d;
    logic             gate_hi_q, gate_hi_d;
    logic             gate_lo_q, gate_lo_d;

    mpc_ctrl_timer #(
        .CTRL_DIV (CTRL_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk   (wb_clk_i),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        u_d     = u_q;
        sw_d    = sw_q;

        if (tick) begin
            u_d = u;
        end

        if (!en) begin
            state_d = IDLE;
            dead_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_d = DT;
                        dead_d  = '0;
                    end
                end
                // u_q cannot change here: the period is longer than the dead-time.
                DT: begin
                    if (dead_q == DEAD_LAST) begin
                        state_d = u_q ? HI : LO;
                        sw_d    = sw_q + 1'b1;
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
                HI: begin
                    if (tick && !u) begin
                        state_d = DT;
                        dead_d  = '0;
                    end
                end
                LO: begin
                    if (tick && u) begin
                        state_d = DT;
                        dead_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Gates are registered decodes of the next state, so they track state_q exactly.
        gate_hi_d = (state_d == HI);
        gate_lo_d = (state_d == LO);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dead_q    <= '0;
            u_q       <= 1'b0;
            sw_q      <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dead_q    <= dead_d;
            u_q       <= u_d;
            sw_q      <= sw_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign gate_hi    = gate_hi_q;
    assign gate_lo    = gate_lo_q;
    assign sample_stb = tick;
    assign sw_cnt     = sw_q;
    assign io_oeb     = 2'b00;

endmodule

// File: tb/tb_mpc_gate_driver.sv
// Directed bench for mpc_gate_driver: CTRL_DIV=10, DEAD_T=3, narrow switch counter so the
// wrap-around can be exercised in a short run.
module tb_mpc_gate_driver;

    localparam int CTRL_DIV = 10;
    localparam int DEAD_T   = 3;
    localparam int CNT_W    = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             u;
    logic             gate_hi;
    logic             gate_lo;
    logic             sample_stb;
    logic [CNT_W-1:0] sw_cnt;
    logic [1:0]       io_oeb;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_n       = 0;
    logic overlap_seen = 1'b0;

    mpc_gate_driver #(
        .CTRL_DIV (CTRL_DIV),
        .DEAD_T   (DEAD_T),
        .CNT_W    (CNT_W)
    ) dut (
        .wb_clk_i   (clk),
        .rst_n      (rst_n),
        .en         (en),
        .u          (u),
        .gate_hi    (gate_hi),
        .gate_lo    (gate_lo),
        .sample_stb (sample_stb),
        .sw_cnt     (sw_cnt),
        .io_oeb     (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gate_hi && gate_lo) overlap_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_to(input int target);
        while (cyc_n < target) cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        u     = 1'b1;
        repeat (3) cyc();

        // Reset state
        cyc_n = 0;
        chk("rst_gate_hi", gate_hi, 0);
        chk("rst_gate_lo", gate_lo, 0);
        chk("rst_sw_cnt", sw_cnt, 0);
        chk("rst_stb", sample_stb, 0);
        chk("io_oeb", io_oeb, 0);
        rst_n = 1'b1;

        // Startup: tick at cycle 9, dead-time 10..12, gate_hi from 13
        for (int k = 1; k <= 13; k++) begin
            run_to(k);
            chk("start_stb", sample_stb, (k == 9));
            chk("start_hi", gate_hi, (k >= 13));
            chk("start_lo", gate_lo, 0);
        end
        chk("start_sw", sw_cnt, 1);

        // Commutation HI -> LO at tick 19
        run_to(14);
        u = 1'b0;
        for (int k = 15; k <= 23; k++) begin
            run_to(k);
            chk("comm_hi", gate_hi, (k <= 19));
            chk("comm_lo", gate_lo, (k >= 23));
            if (k == 22) chk("comm_sw_before", sw_cnt, 1);
        end
        chk("comm_sw", sw_cnt, 2);

        // u pulse between ticks must be ignored
        run_to(24);
        u = 1'b1;
        run_to(27);
        u = 1'b0;
        for (int k = 28; k <= 38; k++) begin
            run_to(k);
            chk("ignore_lo", gate_lo, 1);
            chk("ignore_hi", gate_hi, 0);
            chk("ignore_sw", sw_cnt, 2);
        end

        // LO -> HI at tick 39, then steady u=1 for five periods
        u = 1'b1;
        for (int k = 39; k <= 93; k++) begin
            run_to(k);
            chk("steady_stb", sample_stb, (k % 10 == 9));
            chk("steady_hi", gate_hi, (k >= 43));
            chk("steady_lo", gate_lo, (k <= 39));
            chk("steady_sw", sw_cnt, (k >= 43) ? 3 : 2);
        end

        // en dropped mid dead-time
        run_to(95);
        u = 1'b0;
        run_to(99);
        chk("dt_tick", sample_stb, 1);
        run_to(101);
        chk("dt_hi", gate_hi, 0);
        chk("dt_lo", gate_lo, 0);
        en = 1'b0;
        for (int k = 102; k <= 105; k++) begin
            run_to(k);
            chk("dis_hi", gate_hi, 0);
            chk("dis_lo", gate_lo, 0);
            chk("dis_stb", sample_stb, 0);
            chk("dis_sw", sw_cnt, 3);
        end

        // Re-enable: first strobe on the tenth enabled cycle
        run_to(106);
        en = 1'b1;
        u  = 1'b1;
        for (int k = 106; k <= 119; k++) begin
            run_to(k);
            chk("reen_stb", sample_stb, (k == 115));
            chk("reen_hi", gate_hi, (k >= 119));
            chk("reen_lo", gate_lo, 0);
        end
        chk("reen_sw", sw_cnt, 4);

        // Reset asserted mid-operation
        run_to(121);
        rst_n = 1'b0;
        cyc();
        chk("midrst_hi", gate_hi, 0);
        chk("midrst_lo", gate_lo, 0);
        chk("midrst_sw", sw_cnt, 0);
        chk("midrst_stb", sample_stb, 0);
        rst_n = 1'b1;
        cyc_n = 0;

        // Toggle u every tick: 2^CNT_W + 1 commutations wrap the counter to 1
        for (int i = 0; i <= (1 << CNT_W); i++) begin
            int w;
            w = 0;
            while (!sample_stb && w < 2 * CTRL_DIV) begin
                cyc();
                w++;
            end
            if (!sample_stb) begin
                chk("wrap_timeout", 0, 1);
                break;
            end
            if (i == (1 << CNT_W) - 1) chk("wrap_sw_max", sw_cnt, (1 << CNT_W) - 1);
            if (i == (1 << CNT_W)) chk("wrap_sw_zero", sw_cnt, 0);
            u = (i % 2 == 0);
            cyc();
        end
        repeat (DEAD_T + 2) cyc();
        chk("wrap_sw_one", sw_cnt, 1);
        chk("wrap_hi", gate_hi, 1);
        chk("wrap_lo", gate_lo, 0);
        chk("no_overlap", overlap_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
